// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator controller: opcodes, FSM states and ALU codes.
package acc_ctrl_pkg;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StWb     = 3'd3,
      StHalt   = 3'd4
   } state_e;

   localparam logic [3:0] OpNop  = 4'h0;
   localparam logic [3:0] OpLda  = 4'h1;
   localparam logic [3:0] OpSta  = 4'h2;
   localparam logic [3:0] OpAdd  = 4'h3;
   localparam logic [3:0] OpSub  = 4'h4;
   localparam logic [3:0] OpAnd  = 4'h5;
   localparam logic [3:0] OpOr   = 4'h6;
   localparam logic [3:0] OpNot  = 4'h7;
   localparam logic [3:0] OpJz   = 4'h8;
   localparam logic [3:0] OpHalt = 4'hF;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluNot = 3'b100;

   // Opcodes 9..E are unassigned and execute as a NOP.
   function automatic logic is_illegal(input logic [3:0] op);
      return (op >= 4'h9) && (op <= 4'hE);
   endfunction

   // Opcodes that use the ALU and therefore need a write-back cycle.
   function automatic logic is_alu(input logic [3:0] op);
      return (op >= OpAdd) && (op <= OpNot);
   endfunction

   function automatic logic [2:0] alu_code(input logic [3:0] op);
      logic [2:0] code;
      case (op)
         OpAdd:   code = AluAdd;
         OpSub:   code = AluSub;
         OpAnd:   code = AluAnd;
         OpOr:    code = AluOr;
         OpNot:   code = AluNot;
         default: code = AluAdd;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/acc_ctrl_decode.sv
// Combinational control decode: maps the current FSM state and the latched
// instruction onto the datapath strobes and status outputs (Moore outputs only).
module acc_ctrl_decode
   import acc_ctrl_pkg::*;
(
   input  logic [2:0] state,
   input  logic [3:0] op,
   input  logic [1:0] sel,
   output logic       fetch_req,
   output logic       halted,
   output logic       illegal,
   output logic       LoadAcc,
   output logic       DumpAcc,
   output logic       LoadReg,
   output logic       DumpReg,
   output logic [1:0] RegSel,
   output logic       AccSrc,
   output logic [2:0] AluOp,
   output logic       AluLatch
);

   // Every output defaults to idle; each state raises only what it owns.
   always_comb begin
      fetch_req = 1'b0;
      halted    = 1'b0;
      illegal   = 1'b0;
      LoadAcc   = 1'b0;
      DumpAcc   = 1'b0;
      LoadReg   = 1'b0;
      DumpReg   = 1'b0;
      RegSel    = 2'b00;
      AccSrc    = 1'b0;
      AluOp     = AluAdd;
      AluLatch  = 1'b0;
      case (state)
         StFetch: begin
            fetch_req = 1'b1;
         end
         StDecode: begin
            illegal = is_illegal(op);
         end
         StExec: begin
            case (op)
               OpLda: begin
                  DumpReg = 1'b1;
                  RegSel  = sel;
                  AccSrc  = 1'b0;
                  LoadAcc = 1'b1;
               end
               OpSta: begin
                  DumpAcc = 1'b1;
                  LoadReg = 1'b1;
                  RegSel  = sel;
               end
               OpAdd, OpSub, OpAnd, OpOr: begin
                  DumpReg  = 1'b1;
                  RegSel   = sel;
                  AluLatch = 1'b1;
                  AluOp    = alu_code(op);
               end
               // NOT is unary: no operand B is captured.
               OpNot: begin
                  AluOp = AluNot;
               end
               default: begin
               end
            endcase
         end
         StWb: begin
            if (is_alu(op)) begin
               AluOp   = alu_code(op);
               AccSrc  = 1'b1;
               LoadAcc = 1'b1;
            end
         end
         StHalt: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/acc_ctrl.sv
// Accumulator-machine controller: fetch/decode/execute/write-back FSM,
// program counter and instruction register. Strobes come from acc_ctrl_decode.
module acc_ctrl
   import acc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] instr,
   input  logic       instr_valid,
   input  logic       acc_zero,
   output logic       fetch_req,
   output logic [7:0] pc,
   output logic       LoadAcc,
   output logic       DumpAcc,
   output logic       LoadReg,
   output logic       DumpReg,
   output logic [1:0] RegSel,
   output logic       AccSrc,
   output logic [2:0] AluOp,
   output logic       AluLatch,
   output logic       halted,
   output logic       illegal
);

   state_e     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] ir_q, ir_d;
   logic [3:0] op;

   assign op = ir_q[7:4];
   assign pc = pc_q;

   // State, PC and IR registers; reset wins over every transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
         pc_q    <= 8'h00;
         ir_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state, PC and IR update.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         StFetch: begin
            if (instr_valid) begin
               ir_d    = instr;
               pc_d    = pc_q + 8'd1;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (op == OpHalt) begin
               state_d = StHalt;
            end else if ((op == OpNop) || is_illegal(op)) begin
               state_d = StFetch;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            // pc_q already points past the JZ, so only its low nibble is replaced.
            if ((op == OpJz) && acc_zero) begin
               pc_d = {pc_q[7:4], ir_q[3:0]};
            end
            state_d = is_alu(op) ? StWb : StFetch;
         end
         StWb: begin
            state_d = StFetch;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StFetch;
         end
      endcase
   end

   acc_ctrl_decode u_decode (
      .state     (state_q),
      .op        (op),
      .sel       (ir_q[1:0]),
      .fetch_req (fetch_req),
      .halted    (halted),
      .illegal   (illegal),
      .LoadAcc   (LoadAcc),
      .DumpAcc   (DumpAcc),
      .LoadReg   (LoadReg),
      .DumpReg   (DumpReg),
      .RegSel    (RegSel),
      .AccSrc    (AccSrc),
      .AluOp     (AluOp),
      .AluLatch  (AluLatch)
   );

endmodule

// File: tb/tb_acc_ctrl.sv
// Self-checking bench for acc_ctrl: directed scenarios plus a randomized
// instruction stream checked against a per-instruction behavioural model.
module tb_acc_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] instr;
   logic       instr_valid;
   logic       acc_zero;
   logic       fetch_req;
   logic [7:0] pc;
   logic       LoadAcc, DumpAcc, LoadReg, DumpReg, AccSrc, AluLatch, halted, illegal;
   logic [1:0] RegSel;
   logic [2:0] AluOp;

   int total = 0;
   int bad   = 0;
   int cycles = 0;
   logic [7:0] mpc;

   // {LoadAcc, DumpAcc, LoadReg, DumpReg, RegSel, AccSrc, AluOp, AluLatch}
   wire [10:0] ctl = {LoadAcc, DumpAcc, LoadReg, DumpReg, RegSel, AccSrc, AluOp, AluLatch};

   always #5 clk = ~clk;

   acc_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .acc_zero    (acc_zero),
      .fetch_req   (fetch_req),
      .pc          (pc),
      .LoadAcc     (LoadAcc),
      .DumpAcc     (DumpAcc),
      .LoadReg     (LoadReg),
      .DumpReg     (DumpReg),
      .RegSel      (RegSel),
      .AccSrc      (AccSrc),
      .AluOp       (AluOp),
      .AluLatch    (AluLatch),
      .halted      (halted),
      .illegal     (illegal)
   );

   // Strobe exclusivity is checked on every falling edge for the whole run.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         total++;
         if ((LoadAcc === 1'b1 && DumpAcc === 1'b1) || (DumpAcc === 1'b1 && DumpReg === 1'b1) ||
             (LoadReg === 1'b1 && DumpReg === 1'b1)) begin
            bad++;
            $display("FAIL exclusivity t=%0t got ctl=%b required no overlapping strobes", $time, ctl);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cycles++;
   endtask

   // Expected strobes for a given phase (2 = EXEC, 3 = WB), from the instruction table.
   function automatic logic [10:0] exp_ctl(input logic [3:0] op, input logic [1:0] n, input int ph);
      logic [10:0] e;
      e = '0;
      if (ph == 2) begin
         if (op == 4'h1) e = {1'b1, 1'b0, 1'b0, 1'b1, n, 1'b0, 3'b000, 1'b0};
         else if (op == 4'h2) e = {1'b0, 1'b1, 1'b1, 1'b0, n, 1'b0, 3'b000, 1'b0};
         else if (op >= 4'h3 && op <= 4'h6)
            e = {1'b0, 1'b0, 1'b0, 1'b1, n, 1'b0, 3'(op - 4'h3), 1'b1};
         else if (op == 4'h7) e = {7'b0, 3'b100, 1'b0};
      end else if (ph == 3) begin
         if (op >= 4'h3 && op <= 4'h6) e = {1'b1, 5'b0, 1'b1, 3'(op - 4'h3), 1'b0};
         else if (op == 4'h7) e = {1'b1, 5'b0, 1'b1, 3'b100, 1'b0};
      end
      return e;
   endfunction

   function automatic int exp_cycles(input logic [3:0] op);
      if (op >= 4'h3 && op <= 4'h7) return 4;
      if (op == 4'h1 || op == 4'h2 || op == 4'h8) return 3;
      return 2;
   endfunction

   // Issue one non-HALT instruction from FETCH and check every cycle until FETCH returns.
   task automatic run_instr(input logic [7:0] ins, input logic az);
      logic [3:0] op;
      int cyc;
      logic [10:0] e;
      logic exp_ill;
      op = ins[7:4];
      total++;
      if (fetch_req !== 1'b1 || ctl !== 11'b0 || pc !== mpc) begin
         bad++;
         $display("FAIL fetch_state ins=%h got fetch_req=%b ctl=%b pc=%h required 1 0 %h",
                  ins, fetch_req, ctl, pc, mpc);
      end
      instr = ins;
      instr_valid = 1'b1;
      acc_zero = az;
      tick();
      instr_valid = 1'b0;
      instr = 8'($urandom);
      mpc = mpc + 8'd1;
      cyc = 1;
      for (int ph = 1; ph <= 6; ph++) begin
         if (fetch_req === 1'b1) break;
         cyc++;
         e = exp_ctl(op, ins[1:0], ph);
         exp_ill = (ph == 1) && (op >= 4'h9) && (op <= 4'hE);
         total++;
         if (ctl !== e) begin
            bad++;
            $display("FAIL strobes ins=%h phase=%0d got %b required %b", ins, ph, ctl, e);
         end
         total++;
         if (illegal !== exp_ill) begin
            bad++;
            $display("FAIL illegal ins=%h phase=%0d got %b required %b", ins, ph, illegal, exp_ill);
         end
         if (ph == 1) begin
            total++;
            if (pc !== mpc) begin
               bad++;
               $display("FAIL pc_decode ins=%h got %h required %h", ins, pc, mpc);
            end
         end
         if (ph == 2 && op == 4'h8 && az) mpc = {mpc[7:4], ins[3:0]};
         tick();
      end
      total++;
      if (cyc !== exp_cycles(op)) begin
         bad++;
         $display("FAIL cycles ins=%h got %0d required %0d", ins, cyc, exp_cycles(op));
      end
      total++;
      if (pc !== mpc) begin
         bad++;
         $display("FAIL pc_after ins=%h got %h required %h", ins, pc, mpc);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mpc = 8'h00;
   endtask

   task automatic test_reset();
      instr_valid = 1'b0;
      instr = 8'h00;
      acc_zero = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      mpc = 8'h00;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (pc !== 8'h00 || fetch_req !== 1'b1 || ctl !== 11'b0 || halted !== 1'b0 ||
             illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got pc=%h fetch_req=%b ctl=%b halted=%b illegal=%b required 00 1 0 0 0",
                     i, pc, fetch_req, ctl, halted, illegal);
         end
         tick();
      end
   endtask

   task automatic test_stream();
      int start;
      do_reset();
      start = cycles;
      run_instr(8'h11, 1'b0);
      run_instr(8'h32, 1'b0);
      run_instr(8'h23, 1'b0);
      total++;
      if (cycles - start !== 10) begin
         bad++;
         $display("FAIL stream_cycles got %0d required 10", cycles - start);
      end
      total++;
      if (pc !== 8'h03) begin
         bad++;
         $display("FAIL stream_pc got %h required 03", pc);
      end
   endtask

   task automatic test_jz();
      do_reset();
      while (mpc != 8'h43) run_instr(8'h00, 1'b0);
      run_instr(8'h8A, 1'b1);
      total++;
      if (pc !== 8'h4A) begin
         bad++;
         $display("FAIL jz_taken got %h required 4A", pc);
      end
      run_instr(8'h8A, 1'b0);
      total++;
      if (pc !== 8'h4B) begin
         bad++;
         $display("FAIL jz_not_taken got %h required 4B", pc);
      end
   endtask

   task automatic test_illegal();
      int pulses;
      logic [7:0] start_pc;
      start_pc = pc;
      pulses = 0;
      instr = 8'hB0;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (illegal === 1'b1) pulses++;
         total++;
         if (ctl !== 11'b0) begin
            bad++;
            $display("FAIL illegal_strobes cyc=%0d got %b required 0", i, ctl);
         end
         tick();
      end
      total++;
      if (pulses !== 1) begin
         bad++;
         $display("FAIL illegal_pulses got %0d required 1", pulses);
      end
      total++;
      if (pc !== start_pc + 8'd1) begin
         bad++;
         $display("FAIL illegal_pc got %h required %h", pc, start_pc + 8'd1);
      end
      mpc = start_pc + 8'd1;
      for (int op = 9; op <= 14; op++) run_instr({4'(op), 4'($urandom)}, 1'($urandom));
   endtask

   task automatic test_reset_mid();
      // Reset during WB of SUB R0.
      instr = 8'h40;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      tick();
      total++;
      if (LoadAcc !== 1'b1 || AccSrc !== 1'b1 || AluOp !== 3'b001) begin
         bad++;
         $display("FAIL sub_wb got LoadAcc=%b AccSrc=%b AluOp=%b required 1 1 001",
                  LoadAcc, AccSrc, AluOp);
      end
      do_reset();
      total++;
      if (LoadAcc !== 1'b0 || ctl !== 11'b0 || pc !== 8'h00 || fetch_req !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_wb got LoadAcc=%b ctl=%b pc=%h fetch_req=%b required 0 0 00 1",
                  LoadAcc, ctl, pc, fetch_req);
      end
      // Reset during EXEC of LDA R2.
      instr = 8'h12;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      do_reset();
      total++;
      if (ctl !== 11'b0 || pc !== 8'h00 || fetch_req !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_exec got ctl=%b pc=%h fetch_req=%b required 0 00 1",
                  ctl, pc, fetch_req);
      end
   endtask

   task automatic test_random();
      logic [7:0] ins;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         ins = 8'($urandom);
         if (ins[7:4] == 4'hF) ins[7:4] = 4'h7;
         run_instr(ins, 1'($urandom));
      end
   endtask

   task automatic test_wrap();
      do_reset();
      while (mpc != 8'hFF) run_instr({4'($urandom_range(9, 14)), 4'($urandom)}, 1'b0);
      run_instr(8'h00, 1'b0);
      total++;
      if (pc !== 8'h00) begin
         bad++;
         $display("FAIL pc_wrap got %h required 00", pc);
      end
   endtask

   task automatic test_halt();
      logic [7:0] hpc;
      hpc = pc + 8'd1;
      instr = 8'hF0;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) begin
         instr = 8'($urandom);
         instr_valid = 1'($urandom);
         total++;
         if (halted !== 1'b1 || fetch_req !== 1'b0 || ctl !== 11'b0 || illegal !== 1'b0 ||
             pc !== hpc) begin
            bad++;
            $display("FAIL halt_hold cyc=%0d got halted=%b fetch_req=%b ctl=%b illegal=%b pc=%h required 1 0 0 0 %h",
                     i, halted, fetch_req, ctl, illegal, pc, hpc);
         end
         tick();
      end
      instr_valid = 1'b0;
      do_reset();
      total++;
      if (halted !== 1'b0 || fetch_req !== 1'b1 || pc !== 8'h00) begin
         bad++;
         $display("FAIL halt_exit got halted=%b fetch_req=%b pc=%h required 0 1 00",
                  halted, fetch_req, pc);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_jz();
      test_illegal();
      test_reset_mid();
      test_random();
      test_wrap();
      test_halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
